sigma_delta_adc_harness: RTL and testbench

Behavioural-plus-RTL sigma-delta ADC test harness: a real-valued model of the analog front end, plus a synthesizable CIC decimator.
- Front end: a comparator and an RC integrator closing a 1-bit feedback loop, which turns a real voltage on `adc_input` into a PDM bitstream.
- Decimator: a STGS-stage CIC filter that decimates by BOSR and emits unsigned WDTH-bit samples with a one-cycle valid strobe.
- Sits between an analog stimulus generator and downstream audio/sample consumers in simulation benches.

---
 rtl/sigma_delta_pkg.sv | 13 +
 rtl/cic_decimator.sv | 89 ++++++++
 rtl/sigma_delta_adc_harness.sv | 45 ++++
 tb/tb_sigma_delta_adc_harness.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_delta_pkg.sv
// Shared constants and sizing helpers for the sigma-delta ADC harness and its CIC decimator.
package sigma_delta_pkg;

    localparam real VCC_DEFAULT  = 2.5;
    localparam int  DEFAULT_BOSR = 256;
    localparam int  DEFAULT_STGS = 2;

    // CIC growth is STGS*log2(BOSR) bits over the 1-bit input, plus headroom for full scale.
    function automatic int cic_width(input int stgs, input int bosr);
        return stgs * $clog2(bosr) + 2;
    endfunction

endpackage

// File: rtl/cic_decimator.sv
// STGS-stage CIC decimator: integrators at the bit rate, combs once per BOSR clocks,
// one pipeline register per comb stage, then a held output with a one-clock valid strobe.
module cic_decimator
    import sigma_delta_pkg::*;
#(
    parameter int BOSR = DEFAULT_BOSR,
    parameter int STGS = DEFAULT_STGS,
    parameter int WDTH = cic_width(DEFAULT_STGS, DEFAULT_BOSR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pdm_in,
    output logic [WDTH-1:0] data_out,
    output logic            valid_out
);

    localparam int CW = $clog2(BOSR);

    logic [CW-1:0]   cnt_reg;
    logic            tick;
    logic [WDTH-1:0] integ_w [STGS];
    logic [WDTH-1:0] comb_w  [STGS];
    logic [STGS-1:0] vld_w;

    assign tick = (cnt_reg == CW'(BOSR - 1));

    // BOSR is a power of two, so the counter wraps on its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < STGS; gi++) begin : g_stage
        logic [WDTH-1:0] integ_reg;
        logic [WDTH-1:0] comb_reg;
        logic [WDTH-1:0] dly_reg;
        logic            vld_reg;
        logic [WDTH-1:0] integ_in;
        logic [WDTH-1:0] comb_in;
        logic            comb_en;

        if (gi == 0) begin : g_first
            assign integ_in = {{(WDTH-1){1'b0}}, pdm_in};
            assign comb_in  = integ_w[STGS-1];
            assign comb_en  = tick;
        end else begin : g_rest
            assign integ_in = integ_w[gi-1];
            assign comb_in  = comb_w[gi-1];
            assign comb_en  = vld_w[gi-1];
        end

        // Integrators wrap modulo 2**WDTH; the combs undo the wrap exactly.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                integ_reg <= '0;
                comb_reg  <= '0;
                dly_reg   <= '0;
                vld_reg   <= 1'b0;
            end else begin
                integ_reg <= integ_reg + integ_in;
                vld_reg   <= comb_en;
                if (comb_en) begin
                    comb_reg <= comb_in - dly_reg;
                    dly_reg  <= comb_in;
                end
            end
        end

        assign integ_w[gi] = integ_reg;
        assign comb_w[gi]  = comb_reg;
        assign vld_w[gi]   = vld_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= vld_w[STGS-1];
            if (vld_w[STGS-1]) begin
                data_out <= comb_w[STGS-1];
            end
        end
    end

endmodule

// File: rtl/sigma_delta_adc_harness.sv
// Sigma-delta ADC harness: real-valued comparator + RC integrator front end producing a PDM
// stream, decimated to WDTH-bit unsigned samples by the CIC decimator.
module sigma_delta_adc_harness
    import sigma_delta_pkg::*;
#(
    parameter real VCC       = VCC_DEFAULT,
    parameter int  CAP_FUDGE = 128,
    parameter int  BOSR      = DEFAULT_BOSR,
    parameter int  STGS      = DEFAULT_STGS,
    parameter int  WDTH      = cic_width(STGS, BOSR)
) (
    input  logic            clk,
    input  logic            rst,
    input  real             adc_input,
    output logic [WDTH-1:0] adc_output,
    output logic            adc_valid
);

    real  v_cap_reg;
    logic pdm_reg;

    // The capacitor is driven by last cycle's decision, closing the 1-bit loop with one clock of delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_cap_reg <= 0.0;
            pdm_reg   <= 1'b0;
        end else begin
            pdm_reg   <= (adc_input > v_cap_reg);
            v_cap_reg <= v_cap_reg + ((pdm_reg ? VCC : 0.0) - v_cap_reg) / real'(CAP_FUDGE);
        end
    end

    cic_decimator #(
        .BOSR (BOSR),
        .STGS (STGS),
        .WDTH (WDTH)
    ) u_cic (
        .clk       (clk),
        .rst       (rst),
        .pdm_in    (pdm_reg),
        .data_out  (adc_output),
        .valid_out (adc_valid)
    );

endmodule

// File: tb/tb_sigma_delta_adc_harness.sv
// Bench for the sigma-delta harness: a reference loop model plus a triangular-window FIR view of
// the 2-stage CIC predicts every sample and its strobe clock; a queue pairs them with DUT strobes.
module tb_sigma_delta_adc_harness;

    localparam int  BOSR      = 256;
    localparam int  STGS      = 2;
    localparam int  WDTH      = 18;
    localparam int  CAP_FUDGE = 128;
    localparam real VCC       = 2.5;
    localparam int  HIST      = 1024;
    localparam real PI        = 3.14159265358979;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    real             adc_input = 0.0;
    logic [WDTH-1:0] adc_output;
    logic            adc_valid;

    sigma_delta_adc_harness #(
        .VCC       (VCC),
        .CAP_FUDGE (CAP_FUDGE),
        .BOSR      (BOSR),
        .STGS      (STGS),
        .WDTH      (WDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adc_input  (adc_input),
        .adc_output (adc_output),
        .adc_valid  (adc_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WDTH-1:0] val;
        int              due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    real  m_vc;
    bit   m_pdm;
    int   m_edge;
    bit   m_hist [HIST];
    int   out_idx;

    bit   band_en = 1'b0;
    int   band_lo = 0;
    int   band_hi = 0;
    bit   msb_chk = 1'b0;
    bit   track   = 1'b0;
    int   seen_max = 0;
    int   seen_min = 1 << 30;

    // Two cascaded boxcars of length BOSR form a triangle of taps 1..BOSR..1; d counts back
    // from the newest bit that can reach the m-th output.
    function automatic int cic_ref(input int m);
        int acc;
        int k;
        int w;
        acc = 0;
        for (int d = 1; d < 2 * BOSR; d++) begin
            k = m * BOSR - 2 - d;
            w = (d <= BOSR) ? d : 2 * BOSR - d;
            if (k >= 0 && m_hist[k % HIST]) acc += w;
        end
        return acc;
    endfunction

    task automatic model_reset();
        m_vc    = 0.0;
        m_pdm   = 1'b0;
        m_edge  = 0;
        out_idx = 0;
        for (int i = 0; i < HIST; i++) m_hist[i] = 1'b0;
        sb.delete();
    endtask

    task automatic model_edge();
        bit   nxt;
        exp_t e;
        m_edge++;
        nxt   = (adc_input > m_vc);
        m_vc  = m_vc + ((m_pdm ? VCC : 0.0) - m_vc) / 128.0;
        m_pdm = nxt;
        m_hist[m_edge % HIST] = m_pdm;
        if (m_edge % BOSR == 0) begin
            e.val = WDTH'(cic_ref(m_edge / BOSR));
            e.due = m_edge + STGS;
            sb.push_back(e);
        end
    endtask

    task automatic check_out();
        bit   due;
        exp_t e;
        due = (sb.size() > 0) && (sb[0].due == m_edge);
        if (adc_valid !== 1'b0 || due) begin
            checks++;
            assert (adc_valid === due) else begin
                errors++;
                $error("FAIL strobe clk=%0d adc_valid=%b required=%b", m_edge, adc_valid, due);
            end
        end
        if (due) begin
            e = sb.pop_front();
            out_idx++;
            checks++;
            assert (adc_output === e.val) else begin
                errors++;
                $error("FAIL sample #%0d clk=%0d adc_output=%0d required=%0d", out_idx, m_edge, adc_output, e.val);
            end
            if (band_en && out_idx >= 3) begin
                checks++;
                assert (int'(adc_output) >= band_lo && int'(adc_output) <= band_hi) else begin
                    errors++;
                    $error("FAIL band #%0d adc_output=%0d required=%0d..%0d", out_idx, adc_output, band_lo, band_hi);
                end
            end
            if (msb_chk) begin
                checks++;
                assert (adc_output[WDTH-1] === 1'b0) else begin
                    errors++;
                    $error("FAIL msb #%0d adc_output=%0d required msb=0", out_idx, adc_output);
                end
            end
            if (track && out_idx >= 3) begin
                if (int'(adc_output) > seen_max) seen_max = int'(adc_output);
                if (int'(adc_output) < seen_min) seen_min = int'(adc_output);
            end
            $display("sample #%0d clk=%0d adc_output=%0d expected=%0d", out_idx, m_edge, adc_output, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_out();
    endtask

    // Called at a falling edge; release lands on a falling edge so the next rise is clock 1.
    task automatic do_reset(input int n);
        rst = 1'b0;
        #1;
        checks++;
        assert (adc_output === '0) else begin
            errors++;
            $error("FAIL reset_out adc_output=%0d required=0", adc_output);
        end
        checks++;
        assert (adc_valid === 1'b0) else begin
            errors++;
            $error("FAIL reset_valid adc_valid=%b required=0", adc_valid);
        end
        model_reset();
        repeat (n) begin
            @(negedge clk);
            checks++;
            assert (adc_valid === 1'b0 && adc_output === '0) else begin
                errors++;
                $error("FAIL in_reset adc_valid=%b adc_output=%0d required=0/0", adc_valid, adc_output);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);

        // Cadence: strobe timing is checked against the queue on every clock.
        adc_input = 0.7;
        do_reset(3);
        repeat (4000) tick();

        // DC mid-scale
        adc_input = 1.25;
        do_reset(3);
        band_en = 1'b1; band_lo = 32768 - 330; band_hi = 32768 + 330;
        repeat (6 * BOSR + 4) tick();

        // DC low
        adc_input = 0.0;
        do_reset(3);
        band_lo = 0; band_hi = 0;
        repeat (4 * BOSR + 4) tick();
        band_en = 1'b0;

        // DC high: close to full scale without wrapping into the top bit
        adc_input = 0.99 * VCC;
        do_reset(3);
        msb_chk = 1'b1;
        repeat (5 * BOSR + 4) tick();
        msb_chk = 1'b0;

        // Reset in the middle of a run
        adc_input = 1.25;
        do_reset(3);
        repeat (999) tick();
        do_reset(5);
        band_en = 1'b1; band_lo = 32768 - 330; band_hi = 32768 + 330;
        repeat (3 * BOSR + 4) tick();
        band_en = 1'b0;

        // Sine
        adc_input = 1.25 + 1.2375;
        do_reset(3);
        track = 1'b1;
        for (int n = 0; n < 128 * BOSR; n++) begin
            adc_input = 1.25 + 1.2375 * $cos(2.0 * PI * 440.0 * real'(n) / (44800.0 * 256.0));
            tick();
        end
        track = 1'b0;
        checks++;
        assert (seen_max > 63000) else begin
            errors++;
            $error("FAIL sine_peak max=%0d required>63000", seen_max);
        end
        checks++;
        assert (seen_min < 2500) else begin
            errors++;
            $error("FAIL sine_trough min=%0d required<2500", seen_min);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
